// File: rtl/il2_fill_responder.sv
// L2-side IL1 refill streamer plus the inst/data inclusive back-invalidate handshakes.
// The fill FSM and the two replace channels run fully independently.
package il2_fill_pkg;
    localparam int IL2_BEAT_W = 2;  // $clog2(CACHE_BLOCK_SIZE/8) for the 32-byte line
    typedef struct packed {
        logic                  update;
        logic [IL2_BEAT_W-1:0] addr_update;
        logic [31:0]           w1_update;
        logic [31:0]           w2_update;
    } cache_update_type;
endpackage

module il2_replace_ch #(
    parameter int LINE_ADDR_W = 27
) (
    input  logic                   clk_l2,
    input  logic                   rst_n,
    input  logic                   evict_valid,
    input  logic [LINE_ADDR_W-1:0] evict_addr,
    output logic                   evict_ready,
    output logic                   replace_req,
    output logic [LINE_ADDR_W-1:0] addr_replace,
    input  logic                   replace_il1_ack,
    output logic                   l2_il1_ack,
    output logic                   inv_done
);
    typedef enum logic [1:0] {R_IDLE, R_REQ, R_WAIT, R_ACK} r_state_t;
    r_state_t state, nxt;
    logic     accept;

    assign accept      = (state == R_IDLE) && evict_valid && evict_ready;
    assign replace_req = (state == R_REQ);
    assign l2_il1_ack  = (state == R_ACK);

    // R_REQ always moves on to R_WAIT, so an ack already high there is seen in R_WAIT
    always_comb begin
        nxt = state;
        case (state)
            R_IDLE:  if (accept) nxt = R_REQ;
            R_REQ:   nxt = R_WAIT;
            R_WAIT:  if (replace_il1_ack) nxt = R_ACK;
            R_ACK:   if (!replace_il1_ack) nxt = R_IDLE;
            default: nxt = R_IDLE;
        endcase
    end

    // ready is registered so it stays low while reset is asserted
    always_ff @(posedge clk_l2 or negedge rst_n) begin
        if (!rst_n) begin
            state        <= R_IDLE;
            evict_ready  <= 1'b0;
            inv_done     <= 1'b0;
            addr_replace <= '0;
        end else begin
            state       <= nxt;
            evict_ready <= (nxt == R_IDLE);
            inv_done    <= (state == R_ACK) && !replace_il1_ack;
            if (accept) addr_replace <= evict_addr;
        end
    end
endmodule

module il2_fill_responder
    import il2_fill_pkg::*;
#(
    parameter int PC_LENGTH        = 32,
    parameter int CACHE_BLOCK_SIZE = 32,
    parameter int LINE_ADDR_W      = 27
) (
    input  logic                          clk_l2,
    input  logic                          rst_n,
    input  logic                          inst_update_req,
    input  logic [PC_LENGTH-1:0]          pc_up,
    output cache_update_type              IL2_out,
    output logic                          l2_rd_req,
    output logic [LINE_ADDR_W-1:0]        l2_rd_addr,
    input  logic                          l2_rd_valid,
    input  logic [CACHE_BLOCK_SIZE*8-1:0] l2_rd_data,
    input  logic                          inst_evict_valid,
    input  logic [LINE_ADDR_W-1:0]        inst_evict_addr,
    output logic                          inst_evict_ready,
    output logic                          inst_replace_req,
    output logic [LINE_ADDR_W-1:0]        inst_addr_replace,
    input  logic                          inst_replace_il1_ack,
    output logic                          L2_inst_il1_ack,
    output logic                          inst_inv_done,
    input  logic                          data_evict_valid,
    input  logic [LINE_ADDR_W-1:0]        data_evict_addr,
    output logic                          data_evict_ready,
    output logic                          data_replace_req,
    output logic [LINE_ADDR_W-1:0]        data_addr_replace,
    input  logic                          data_replace_il1_ack,
    output logic                          L2_data_il1_ack,
    output logic                          data_inv_done
);
    localparam int WORDS       = CACHE_BLOCK_SIZE / 4;
    localparam int BEATS       = CACHE_BLOCK_SIZE / 8;
    localparam int BEAT_W      = $clog2(BEATS);
    localparam int BYTE_OFFSET = 2;
    localparam int WORD_OFFSET = $clog2(WORDS);
    localparam int LINE_LSB    = BYTE_OFFSET + WORD_OFFSET;
    localparam logic [BEAT_W:0] LAST = BEATS[BEAT_W:0];
    localparam int NUM_CH      = 2;

    typedef enum logic [1:0] {F_IDLE, F_READ, F_SEND, F_DROP} f_state_t;
    f_state_t f_state, f_nxt;

    logic [BEAT_W:0]               beat;
    logic [CACHE_BLOCK_SIZE*8-1:0] line_buf, src;
    logic [BEAT_W-1:0]             idx;
    logic                          emit;
    logic [31:0]                   w1_sel, w2_sel;
    logic                          unused_pc;

    assign unused_pc = ^pc_up[LINE_LSB-1:0];
    assign l2_rd_req = (f_state == F_READ);

    // F_DROP only exits on a low request, so F_IDLE never restarts on a stale level
    always_comb begin
        f_nxt = f_state;
        case (f_state)
            F_IDLE:  if (inst_update_req) f_nxt = F_READ;
            F_READ:  if (l2_rd_valid) f_nxt = F_SEND;
            F_SEND:  if (beat == LAST) f_nxt = F_DROP;
            F_DROP:  if (!inst_update_req) f_nxt = F_IDLE;
            default: f_nxt = F_IDLE;
        endcase
    end

    // beat 0 comes straight off the read bus so it lands the cycle after l2_rd_valid
    always_comb begin
        src  = line_buf;
        idx  = beat[BEAT_W-1:0];
        emit = 1'b0;
        if (f_state == F_READ) begin
            src  = l2_rd_data;
            idx  = '0;
            emit = l2_rd_valid;
        end else if (f_state == F_SEND) begin
            emit = (beat != LAST);
        end
        w1_sel = src[32*int'(idx) +: 32];
        w2_sel = src[32*(int'(idx)+BEATS) +: 32];
    end

    always_ff @(posedge clk_l2 or negedge rst_n) begin
        if (!rst_n) begin
            f_state    <= F_IDLE;
            beat       <= '0;
            line_buf   <= '0;
            l2_rd_addr <= '0;
            IL2_out    <= '0;
        end else begin
            f_state <= f_nxt;
            if (f_state == F_IDLE && inst_update_req) l2_rd_addr <= pc_up[PC_LENGTH-1:LINE_LSB];
            if (f_state == F_READ && l2_rd_valid) line_buf <= l2_rd_data;
            if (emit) begin
                IL2_out.update      <= 1'b1;
                IL2_out.addr_update <= idx;
                IL2_out.w1_update   <= w1_sel;
                IL2_out.w2_update   <= w2_sel;
                beat                <= {1'b0, idx} + 1'b1;
            end else begin
                IL2_out <= '0;
            end
        end
    end

    // channel 0 = inst, channel 1 = data
    logic [NUM_CH-1:0]                  ev_valid, ev_ready, rep_req, il1_ack, l2_ack, inv_done;
    logic [NUM_CH-1:0][LINE_ADDR_W-1:0] ev_addr, rep_addr;

    assign ev_valid = {data_evict_valid, inst_evict_valid};
    assign ev_addr  = {data_evict_addr, inst_evict_addr};
    assign il1_ack  = {data_replace_il1_ack, inst_replace_il1_ack};

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        il2_replace_ch #(.LINE_ADDR_W(LINE_ADDR_W)) u_ch (
            .clk_l2          (clk_l2),
            .rst_n           (rst_n),
            .evict_valid     (ev_valid[c]),
            .evict_addr      (ev_addr[c]),
            .evict_ready     (ev_ready[c]),
            .replace_req     (rep_req[c]),
            .addr_replace    (rep_addr[c]),
            .replace_il1_ack (il1_ack[c]),
            .l2_il1_ack      (l2_ack[c]),
            .inv_done        (inv_done[c])
        );
    end

    assign inst_evict_ready  = ev_ready[0];
    assign inst_replace_req  = rep_req[0];
    assign inst_addr_replace = rep_addr[0];
    assign L2_inst_il1_ack   = l2_ack[0];
    assign inst_inv_done     = inv_done[0];
    assign data_evict_ready  = ev_ready[1];
    assign data_replace_req  = rep_req[1];
    assign data_addr_replace = rep_addr[1];
    assign L2_data_il1_ack   = l2_ack[1];
    assign data_inv_done     = inv_done[1];
endmodule
